hazard_unit: RTL

- Companion to the EX-stage forwarding logic; resolves the hazards forwarding cannot resolve.
- Detects load-use hazards, ID-stage branch operand hazards and multi-cycle MUL/DIV HI/LO hazards.
- Drives PC / IF-ID hold and the ID/EX bubble that feeds the forwarding unit; flushes IF/ID on taken branch or jump.
- Contains an IDLE/BUSY FSM with a cycle counter for the MUL/DIV unit, plus a saturating stall-cycle performance counter.

---
 rtl/mips_pkg.sv | 21 ++
 rtl/hazard_unit_if.sv | 42 ++++
 rtl/muldiv_busy_tracker.sv | 58 +++++
 rtl/hazard_unit.sv | 66 ++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline-control definitions: register index type, the zero register
// and the MUL/DIV tracker state encoding.
package mips_pkg;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } muldiv_state_t;

   // A dependency exists only on a real destination; $zero never carries data.
   function automatic logic reg_match(input reg_idx_t r, input reg_idx_t d);
      return (d != REG_ZERO) && (d == r);
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline side is the master,
// the hazard unit is the slave.
interface hazard_unit_if
   import mips_pkg::*;
#(
   parameter int PERF_W = 32
);
   reg_idx_t          RS_ID;
   reg_idx_t          RT_ID;
   logic              UsesRT_ID;
   logic              Branch_ID;
   logic              Taken_ID;
   logic              Jump_ID;
   logic              HiLo_ID;
   logic              RegWrite_EX;
   logic              MemRead_EX;
   reg_idx_t          wrReg_EX;
   logic              MemRead_MEM;
   reg_idx_t          wrReg_MEM;
   logic              MulDiv_Start_EX;
   logic              Stall_IF;
   logic              Stall_ID;
   logic              Flush_EX;
   logic              Flush_ID;
   logic              MulDiv_Busy;
   logic [PERF_W-1:0] Stall_Count;

   modport master (
      output RS_ID, RT_ID, UsesRT_ID, Branch_ID, Taken_ID, Jump_ID, HiLo_ID,
             RegWrite_EX, MemRead_EX, wrReg_EX, MemRead_MEM, wrReg_MEM,
             MulDiv_Start_EX,
      input  Stall_IF, Stall_ID, Flush_EX, Flush_ID, MulDiv_Busy, Stall_Count
   );

   modport slave (
      input  RS_ID, RT_ID, UsesRT_ID, Branch_ID, Taken_ID, Jump_ID, HiLo_ID,
             RegWrite_EX, MemRead_EX, wrReg_EX, MemRead_MEM, wrReg_MEM,
             MulDiv_Start_EX,
      output Stall_IF, Stall_ID, Flush_EX, Flush_ID, MulDiv_Busy, Stall_Count
   );

endinterface

// File: rtl/muldiv_busy_tracker.sv
// Tracks how long a multi-cycle MUL/DIV keeps HI/LO occupied after issue.
// busy is high for exactly CYCLES cycles, starting the cycle after start.
module muldiv_busy_tracker
   import mips_pkg::*;
#(
   parameter int CYCLES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   output logic busy
);

   localparam int CW = $clog2(CYCLES + 1);

   muldiv_state_t state_r;
   logic [CW-1:0] cnt_r;

   // Occupancy FSM; a start while already busy is ignored and never reloads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= {CW{1'b0}};
         busy    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r <= BUSY;
                  cnt_r   <= CW'(CYCLES - 1);
                  busy    <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  cnt_r   <= cnt_r;
                  busy    <= 1'b0;
               end
            end
            BUSY: begin
               if (cnt_r == {CW{1'b0}}) begin
                  state_r <= IDLE;
                  cnt_r   <= cnt_r;
                  busy    <= 1'b0;
               end else begin
                  state_r <= BUSY;
                  cnt_r   <= cnt_r - CW'(1);
                  busy    <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= {CW{1'b0}};
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Resolves hazards the EX forwarding network cannot: load-use, ID-stage branch
// operands and HI/LO access during a multi-cycle MUL/DIV.
module hazard_unit
   import mips_pkg::*;
#(
   parameter int MULDIV_CYCLES = 32,
   parameter int PERF_W        = 32
) (
   input logic         clk,
   input logic         rst_n,
   hazard_unit_if.slave hif
);

   logic              rt_used_s;
   logic              ex_hit_s;
   logic              mem_hit_s;
   logic              load_use_s;
   logic              branch_haz_s;
   logic              hilo_haz_s;
   logic              stall_s;
   logic              busy_s;
   logic [PERF_W-1:0] stall_count_r;

   muldiv_busy_tracker #(
      .CYCLES (MULDIV_CYCLES)
   ) u_tracker (
      .clk   (clk),
      .rst_n (rst_n),
      .start (hif.MulDiv_Start_EX),
      .busy  (busy_s)
   );

   // Hazard detection; branches compare both operands in ID, so rt always counts.
   always_comb begin
      rt_used_s    = hif.UsesRT_ID | hif.Branch_ID;
      ex_hit_s     = reg_match(hif.RS_ID, hif.wrReg_EX)
                   | (rt_used_s & reg_match(hif.RT_ID, hif.wrReg_EX));
      mem_hit_s    = reg_match(hif.RS_ID, hif.wrReg_MEM)
                   | (rt_used_s & reg_match(hif.RT_ID, hif.wrReg_MEM));
      load_use_s   = hif.MemRead_EX & ex_hit_s;
      branch_haz_s = hif.Branch_ID & ((hif.RegWrite_EX & ex_hit_s)
                                    | (hif.MemRead_MEM & mem_hit_s));
      hilo_haz_s   = hif.HiLo_ID & (hif.MulDiv_Start_EX | busy_s);
      stall_s      = load_use_s | branch_haz_s | hilo_haz_s;
   end

   // Stall cycle counter, pinned at all-ones once reached.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_r <= {PERF_W{1'b0}};
      end else if (stall_s && (stall_count_r != {PERF_W{1'b1}})) begin
         stall_count_r <= stall_count_r + PERF_W'(1);
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

   // A stalled branch must not be flushed until its operands are ready.
   assign hif.Stall_IF    = stall_s;
   assign hif.Stall_ID    = stall_s;
   assign hif.Flush_EX    = stall_s;
   assign hif.Flush_ID    = (hif.Taken_ID | hif.Jump_ID) & ~stall_s;
   assign hif.MulDiv_Busy = busy_s;
   assign hif.Stall_Count = stall_count_r;

endmodule
